imem_arbiter: RTL and testbench

Shares the single-port instruction ROM between the fetch path (PC requester) and a load path that reads constants and tables out of ROM. Grants at most one access per cycle and drives the ROM's `ce`/`addr`. Returns the registered read word to the winning requester one cycle later. Sits between `pc_reg`/fetch logic, the load/store unit and `rom`, replacing the direct PC→ROM hookup.

---
 rtl/imem_arbiter.sv | 113 +++++++++++
 tb/tb_imem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction ROM arbiter between the fetch path and the load path.
// Define IMEM_ARB_RR_EN for round-robin; default is fixed priority with a starvation counter.
module imem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic [ADDR_W-1:0] ls_addr,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_err,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);

   logic ls_win;
   logic ls_mis;

   assign ls_mis = ls_addr[1:0] != 2'b00;

`ifdef IMEM_ARB_RR_EN
   typedef enum logic {
      GNT_IF,
      GNT_LS
   } gnt_e;

   gnt_e last_gnt;

   // On conflict the side that was not served most recently wins.
   assign ls_win = ls_req && (!if_req || last_gnt == GNT_IF);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_gnt <= GNT_LS;
      end else if (if_gnt) begin
         last_gnt <= GNT_IF;
      end else if (ls_gnt) begin
         last_gnt <= GNT_LS;
      end
   end
`else
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

   logic [CW-1:0] wait_cnt;

   // A load that has lost MAX_WAIT times overrides fetch priority.
   assign ls_win = ls_req && (!if_req || wait_cnt == WAIT_MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
      end else if (!ls_req || ls_gnt) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`endif

   assign if_gnt = rst && if_req && !ls_win;
   assign ls_gnt = rst && ls_win;

   always_comb begin
      rom_ce   = 1'b0;
      rom_addr = '0;
      unique case (1'b1)
         if_gnt: begin
            rom_ce   = 1'b1;
            rom_addr = if_addr;
         end
         (ls_gnt && !ls_mis): begin
            rom_ce   = 1'b1;
            rom_addr = ls_addr;
         end
         default: begin
            rom_ce   = 1'b0;
            rom_addr = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rvalid <= 1'b0;
         if_rdata  <= '0;
         ls_rvalid <= 1'b0;
         ls_rdata  <= '0;
         ls_err    <= 1'b0;
      end else begin
         if_rvalid <= if_gnt;
         ls_rvalid <= ls_gnt;
         ls_err    <= ls_gnt && ls_mis;
         if (if_gnt) begin
            if_rdata <= rom_data;
         end
         if (ls_gnt) begin
            ls_rdata <= ls_mis ? '0 : rom_data;
         end
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter.
// ROM model returns 0xC0DE0000 | address.
module tb_imem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic [31:0] ls_addr;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;
   logic        ls_err;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;

   int checks = 0;
   int errors = 0;

   imem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .MAX_WAIT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .if_req(if_req),
      .if_addr(if_addr),
      .if_gnt(if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata(if_rdata),
      .ls_req(ls_req),
      .ls_addr(ls_addr),
      .ls_gnt(ls_gnt),
      .ls_rvalid(ls_rvalid),
      .ls_rdata(ls_rdata),
      .ls_err(ls_err),
      .rom_ce(rom_ce),
      .rom_addr(rom_addr),
      .rom_data(rom_data)
   );

   assign rom_data = 32'hC0DE_0000 | rom_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      edge_();
      edge_();
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      rst     = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h0;
      ls_req  = 1'b1;
      ls_addr = 32'h40;

      // reset state, grants suppressed
      edge_();
      mid();
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
      chk("rst_rom_ce", 32'(rom_ce), 32'd0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
      chk("rst_ls_err", 32'(ls_err), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_ls_rdata", ls_rdata, 32'd0);
      if_req = 1'b0;
      ls_req = 1'b0;
      edge_();
      rst = 1'b1;

      // fetch only 0x0, 0x4, 0x8
      for (int i = 0; i < 3; i++) begin
         a = 32'(i * 4);
         if_req  = 1'b1;
         if_addr = a;
         mid();
         chk("fo_if_gnt", 32'(if_gnt), 32'd1);
         chk("fo_ls_gnt", 32'(ls_gnt), 32'd0);
         chk("fo_rom_ce", 32'(rom_ce), 32'd1);
         chk("fo_rom_addr", rom_addr, a);
         edge_();
         chk("fo_if_rvalid", 32'(if_rvalid), 32'd1);
         chk("fo_if_rdata", if_rdata, 32'hC0DE_0000 | a);
      end
      if_req = 1'b0;
      mid();
      chk("idle_rom_ce", 32'(rom_ce), 32'd0);
      chk("idle_rom_addr", rom_addr, 32'd0);
      edge_();
      chk("idle_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("hold_if_rdata", if_rdata, 32'hC0DE_0008);

      // misaligned load, no fetch
      ls_req  = 1'b1;
      ls_addr = 32'h42;
      mid();
      chk("mis_ls_gnt", 32'(ls_gnt), 32'd1);
      chk("mis_rom_ce", 32'(rom_ce), 32'd0);
      chk("mis_rom_addr", rom_addr, 32'd0);
      edge_();
      ls_req = 1'b0;
      chk("mis_ls_rvalid", 32'(ls_rvalid), 32'd1);
      chk("mis_ls_err", 32'(ls_err), 32'd1);
      chk("mis_ls_rdata", ls_rdata, 32'd0);
      edge_();
      chk("mis_ls_rvalid_off", 32'(ls_rvalid), 32'd0);
      chk("mis_ls_err_off", 32'(ls_err), 32'd0);

      // aligned load, no fetch
      ls_req  = 1'b1;
      ls_addr = 32'h20;
      mid();
      chk("al_rom_addr", rom_addr, 32'h20);
      edge_();
      ls_req = 1'b0;
      chk("al_ls_rdata", ls_rdata, 32'hC0DE_0020);
      chk("al_ls_err", 32'(ls_err), 32'd0);
      edge_();
      chk("hold_ls_rdata", ls_rdata, 32'hC0DE_0020);

      // reset in the cycle after a fetch grant drops the access
      if_req  = 1'b1;
      if_addr = 32'h30;
      mid();
      chk("rg_if_gnt", 32'(if_gnt), 32'd1);
      @(posedge clk);
      rst = 1'b0;
      #1;
      chk("rg_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rg_if_rdata", if_rdata, 32'd0);
      chk("rg_ls_rdata", ls_rdata, 32'd0);
      mid();
      chk("rg_if_gnt_low", 32'(if_gnt), 32'd0);
      chk("rg_rom_ce_low", 32'(rom_ce), 32'd0);
      edge_();
      if_req  = 1'b0;
      ls_req  = 1'b1;
      ls_addr = 32'h10;
      rst     = 1'b1;
      mid();
      chk("rr_ls_first", 32'(ls_gnt), 32'd1);
`ifndef IMEM_ARB_RR_EN
      chk("rr_wait0", 32'(dut.wait_cnt), 32'd0);
`endif
      edge_();
      ls_req = 1'b0;
      chk("rr_ls_rdata", ls_rdata, 32'hC0DE_0010);

`ifndef IMEM_ARB_RR_EN
      // starvation: load forced through after MAX_WAIT losses
      do_reset();
      if_req  = 1'b1;
      if_addr = 32'h100;
      ls_req  = 1'b1;
      ls_addr = 32'h40;
      for (int c = 0; c < 4; c++) begin
         mid();
         chk("st_if_gnt", 32'(if_gnt), 32'd1);
         chk("st_ls_gnt", 32'(ls_gnt), 32'd0);
         edge_();
         chk("st_wait", 32'(dut.wait_cnt), 32'(c + 1));
      end
      mid();
      chk("st_ls_win", 32'(ls_gnt), 32'd1);
      chk("st_if_lose", 32'(if_gnt), 32'd0);
      chk("st_rom_addr", rom_addr, 32'h40);
      edge_();
      ls_req = 1'b0;
      chk("st_ls_rvalid", 32'(ls_rvalid), 32'd1);
      chk("st_ls_rdata", ls_rdata, 32'hC0DE_0040);
      chk("st_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("st_wait_clr", 32'(dut.wait_cnt), 32'd0);
      mid();
      chk("st_if_resume", 32'(if_gnt), 32'd1);
      edge_();
      if_req = 1'b0;

      // one-cycle overlap adds exactly one to wait_cnt
      if_req = 1'b1;
      ls_req = 1'b1;
      mid();
      chk("ov_if_gnt", 32'(if_gnt), 32'd1);
      edge_();
      chk("ov_wait1", 32'(dut.wait_cnt), 32'd1);
      if_req = 1'b0;
      mid();
      chk("ov_ls_gnt", 32'(ls_gnt), 32'd1);
      edge_();
      ls_req = 1'b0;
      chk("ov_wait_clr", 32'(dut.wait_cnt), 32'd0);
`else
      // round-robin: alternate IF, LS starting with IF
      do_reset();
      if_req  = 1'b1;
      if_addr = 32'h100;
      ls_req  = 1'b1;
      ls_addr = 32'h40;
      for (int c = 0; c < 4; c++) begin
         mid();
         chk("rr_if_gnt", 32'(if_gnt), 32'(c % 2 == 0));
         chk("rr_ls_gnt", 32'(ls_gnt), 32'(c % 2 == 1));
         edge_();
         chk("rr_if_rvalid", 32'(if_rvalid), 32'(c % 2 == 0));
         chk("rr_ls_rvalid", 32'(ls_rvalid), 32'(c % 2 == 1));
      end
      if_req = 1'b0;
      ls_req = 1'b0;
`endif

      edge_();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
